multu_hilo_unit: RTL

Sequential unsigned multiplier with HI/LO result registers. It is the execution-side responder to the ALU control's multiply signalling: it receives the 6-bit function code and the multiply start request, and performs a 32-cycle shift-add MULTU. It holds the 64-bit product in HI/LO and returns HI or LO to the writeback mux on MFHI/MFLO. It sits in EX beside the ALU and shifter.

---
 rtl/multu_hilo_pkg.sv | 22 ++
 rtl/multu_hilo_unit_hilo_reg.sv | 59 +++++
 rtl/multu_hilo_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multu_hilo_pkg.sv
// -----------------------------------------------------------------------------
// multu_hilo_pkg
// Shared definitions for the EX-stage sequential multiplier.
//   - function codes, common with ALU control (MULTU / MFHI / MFLO)
//   - multiplier FSM state encoding
//   - default operand width
// -----------------------------------------------------------------------------
package multu_hilo_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : multu_hilo_pkg

// File: rtl/multu_hilo_unit_hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// HI/LO result registers with the MFHI/MFLO read mux.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   we           : load {hi, lo} from wdata
//   wdata        : 2*WIDTH product, upper half goes to hi
//   funct        : function code selecting the read mux source
//   hi, lo       : registered HI / LO
//   mf_out       : hi on MFHI, lo on MFLO, otherwise 0 (combinational)
// -----------------------------------------------------------------------------
module hilo_reg
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [5:0]           funct,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [WIDTH-1:0]     mf_out
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] mf_s;

    // HI/LO storage: change only on a completed product or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (we) begin
            hi_r <= wdata[2*WIDTH-1:WIDTH];
            lo_r <= wdata[WIDTH-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Zero-latency read mux for the writeback path
    always_comb begin
        mf_s = '0;
        case (funct)
            MFHI:    mf_s = hi_r;
            MFLO:    mf_s = lo_r;
            default: mf_s = '0;
        endcase
    end

    assign hi     = hi_r;
    assign lo     = lo_r;
    assign mf_out = mf_s;

endmodule : hilo_reg

// File: rtl/multu_hilo_unit.sv
// -----------------------------------------------------------------------------
// multu_hilo_unit
// WIDTH-cycle shift-add unsigned multiplier (MULTU) with HI/LO result
// registers and MFHI/MFLO read-out.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   funct        : function code from ALU control
//   mulreset     : multiply start request (level, sampled on clk rise)
//   a, b         : multiplicand (rs), multiplier (rt)
//   hi, lo       : product registers
//   mf_out       : MFHI/MFLO read value, 0 for any other funct
//   busy         : high while iterating
//   done         : one-cycle pulse when hi/lo take a new product
// -----------------------------------------------------------------------------
module multu_hilo_unit
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         funct,
    input  logic               mulreset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   mf_out,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              iterate_s;
    logic              finish_s;

    logic [CNT_W-1:0]  count_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  upper_r;
    logic [WIDTH-1:0]  lower_r;
    logic              busy_r;
    logic              done_r;

    logic [WIDTH:0]    addend_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH-1:0]  shift_upper_s;
    logic [WIDTH-1:0]  shift_lower_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-edge control decode
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        iterate_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (mulreset && (funct == MULTU)) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                iterate_s = 1'b1;
                if (count_r == LAST_CNT) begin
                    finish_s     = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                // start requests are not looked at here; IDLE follows unconditionally
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // One shift-add step: the (WIDTH+1)-bit sum carries the add carry-out,
    // and shifting {sum, lower} right by one consumes it, so no separate
    // carry register has to survive between iterations.
    always_comb begin
        addend_s = '0;
        if (lower_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = '0;
        end
        sum_s         = {1'b0, upper_r} + addend_s;
        shift_upper_s = sum_s[WIDTH:1];
        shift_lower_s = {sum_s[0], lower_r[WIDTH-1:1]};
    end

    // Datapath registers: operand latch on accept, shift-add while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r <= '0;
            upper_r <= '0;
            lower_r <= '0;
            count_r <= '0;
        end else if (accept_s) begin
            mcand_r <= a;
            upper_r <= '0;
            lower_r <= b;
            count_r <= '0;
        end else if (iterate_s) begin
            mcand_r <= mcand_r;
            upper_r <= shift_upper_s;
            lower_r <= shift_lower_s;
            count_r <= count_r + CNT_W'(1);
        end else begin
            mcand_r <= mcand_r;
            upper_r <= upper_r;
            lower_r <= lower_r;
            count_r <= count_r;
        end
    end

    // Status flags: busy spans the iterations, done marks the HI/LO load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            done_r <= finish_s;
        end
    end

    // The last iteration's shifted value is the finished product
    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo_reg (
        .clk    (clk),
        .reset  (reset),
        .we     (finish_s),
        .wdata  ({shift_upper_s, shift_lower_s}),
        .funct  (funct),
        .hi     (hi),
        .lo     (lo),
        .mf_out (mf_out)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule : multu_hilo_unit
